// File: rtl/outport_pkg.sv
// Shared types for the output port: the CPU-side handshake state.
package outport_pkg;

   typedef enum logic {
      C_IDLE = 1'b0,
      C_HOLD = 1'b1
   } cpu_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: the head word is always on dout.
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // NOTE: storage has no reset; only pointers and count define what is valid, and a resettable array costs flops.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/outport_fifo.sv
// Output port: CPU writes with a held strobe and registered ack, device drains a FWFT FIFO.
module outport_fifo
   import outport_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic             ack,
   output logic             full,
   output logic [AW:0]      count,
   output logic [WIDTH-1:0] dev_q,
   output logic             dev_valid,
   input  logic             dev_take
);

   cpu_state_t state;
   logic       push;
   logic       pop;
   logic       empty;

   // One push per we assertion: only the idle state may push.
   assign push      = (state == C_IDLE) & we & ~full;
   assign pop       = dev_take & ~empty;
   assign dev_valid = ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= C_IDLE;
         ack   <= 1'b0;
      end else begin
         case (state)
            C_IDLE: begin
               if (push) begin
                  state <= C_HOLD;
                  ack   <= 1'b1;
               end else begin
                  ack <= 1'b0;
               end
            end
            C_HOLD: begin
               if (!we) begin
                  state <= C_IDLE;
                  ack   <= 1'b0;
               end
            end
            default: begin
               state <= C_IDLE;
               ack   <= 1'b0;
            end
         endcase
      end
   end

   sync_fifo_fwft #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (d),
      .pop   (pop),
      .dout  (dev_q),
      .count (count),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_outport_fifo.sv
// Directed bench for outport_fifo: vector table plus reset and ordering sequences.
module tb_outport_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AW    = $clog2(DEPTH);

   logic             clk;
   logic             rst_n;
   logic             we;
   logic [WIDTH-1:0] d;
   logic             ack;
   logic             full;
   logic [AW:0]      count;
   logic [WIDTH-1:0] dev_q;
   logic             dev_valid;
   logic             dev_take;

   int n_checks = 0;
   int n_errors = 0;

   outport_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .d         (d),
      .ack       (ack),
      .full      (full),
      .count     (count),
      .dev_q     (dev_q),
      .dev_valid (dev_valid),
      .dev_take  (dev_take)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [7:0] d;
      logic       take;
      logic       ack;
      int         cnt;
      logic       valid;
      logic       full;
      logic [7:0] q;
      logic       chk_q;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic v_we, input logic [7:0] v_d, input logic v_take,
                               input logic e_ack, input int e_cnt, input logic e_valid,
                               input logic e_full, input logic [7:0] e_q, input logic e_chk_q);
      vec_t v;
      v.we = v_we; v.d = v_d; v.take = v_take;
      v.ack = e_ack; v.cnt = e_cnt; v.valid = e_valid; v.full = e_full;
      v.q = e_q; v.chk_q = e_chk_q;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; d = '0; dev_take = 1'b0;

      // Single write held 3 cycles, d changes while held, then drop and drain.
      add(1, 8'hA5, 0, 1, 1, 1, 0, 8'hA5, 1);
      add(1, 8'hFF, 0, 1, 1, 1, 0, 8'hA5, 1);
      add(1, 8'hEE, 0, 1, 1, 1, 0, 8'hA5, 1);
      add(0, 8'h00, 0, 0, 1, 1, 0, 8'hA5, 1);
      add(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
      // Fill with 01..04, no take.
      add(1, 8'h01, 0, 1, 1, 1, 0, 8'h01, 1);
      add(0, 8'h00, 0, 0, 1, 1, 0, 8'h01, 1);
      add(1, 8'h02, 0, 1, 2, 1, 0, 8'h01, 1);
      add(0, 8'h00, 0, 0, 2, 1, 0, 8'h01, 1);
      add(1, 8'h03, 0, 1, 3, 1, 0, 8'h01, 1);
      add(0, 8'h00, 0, 0, 3, 1, 0, 8'h01, 1);
      add(1, 8'h04, 0, 1, 4, 1, 1, 8'h01, 1);
      add(0, 8'h00, 0, 0, 4, 1, 1, 8'h01, 1);
      // Blocked 5th write, then take frees space; push lands one edge later.
      add(1, 8'h05, 0, 0, 4, 1, 1, 8'h01, 1);
      add(1, 8'h05, 0, 0, 4, 1, 1, 8'h01, 1);
      add(1, 8'h05, 1, 0, 3, 1, 0, 8'h02, 1);
      add(1, 8'h05, 0, 1, 4, 1, 1, 8'h02, 1);
      add(0, 8'h00, 0, 0, 4, 1, 1, 8'h02, 1);
      add(0, 8'h00, 1, 0, 3, 1, 0, 8'h03, 1);
      add(0, 8'h00, 1, 0, 2, 1, 0, 8'h04, 1);
      add(0, 8'h00, 1, 0, 1, 1, 0, 8'h05, 1);
      add(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
      // Take while empty is ignored; push coinciding with take on empty keeps the word.
      add(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
      add(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
      add(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
      add(1, 8'h3C, 1, 1, 1, 1, 0, 8'h3C, 1);
      add(0, 8'h00, 0, 0, 1, 1, 0, 8'h3C, 1);
      add(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
      // Simultaneous push/pop at count 2: count holds, head advances, tail gets new word.
      add(1, 8'h21, 0, 1, 1, 1, 0, 8'h21, 1);
      add(0, 8'h00, 0, 0, 1, 1, 0, 8'h21, 1);
      add(1, 8'h22, 0, 1, 2, 1, 0, 8'h21, 1);
      add(0, 8'h00, 0, 0, 2, 1, 0, 8'h21, 1);
      add(1, 8'h23, 1, 1, 2, 1, 0, 8'h22, 1);
      add(0, 8'h00, 1, 0, 1, 1, 0, 8'h23, 1);
      add(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);

      // Power-on reset state.
      #12;
      check("por_ack",   ack,       0);
      check("por_count", count,     0);
      check("por_valid", dev_valid, 0);
      check("por_full",  full,      0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         we = vecs[i].we; d = vecs[i].d; dev_take = vecs[i].take;
         step();
         check($sformatf("v%0d_ack", i),   ack,       vecs[i].ack);
         check($sformatf("v%0d_count", i), count,     vecs[i].cnt);
         check($sformatf("v%0d_valid", i), dev_valid, vecs[i].valid);
         check($sformatf("v%0d_full", i),  full,      vecs[i].full);
         if (vecs[i].chk_q) check($sformatf("v%0d_q", i), dev_q, vecs[i].q);
      end

      // Ordering across pointer wrap: write 10..15, taking every other cycle.
      for (int i = 0; i < 6; i++) begin
         we = 1'b1; d = 8'(8'h10 + i); dev_take = 1'b0;
         step();
         check($sformatf("ord%0d_ack", i), ack, 1);
         we = 1'b0; dev_take = 1'b1;
         check($sformatf("ord%0d_q", i), dev_q, 8'h10 + i);
         check($sformatf("ord%0d_valid", i), dev_valid, 1);
         step();
         check($sformatf("ord%0d_count", i), count, 0);
      end
      dev_take = 1'b0;

      // Asynchronous reset mid-transfer with two words stored and ack high.
      we = 1'b1; d = 8'h77;
      step();
      we = 1'b0;
      step();
      we = 1'b1; d = 8'h78;
      step();
      check("pre_rst_count", count, 2);
      check("pre_rst_ack",   ack,   1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_ack",   ack,       0);
      check("rst_count", count,     0);
      check("rst_valid", dev_valid, 0);
      check("rst_full",  full,      0);
      we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_rst_count", count, 0);
      we = 1'b1; d = 8'h5A;
      step();
      check("post_rst_ack", ack,   1);
      check("post_rst_q",   dev_q, 8'h5A);
      we = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
